iter_mult_unit: RTL and testbench
=================================

ITER_MULT_UNIT -- requirements
Module: iter_mult_unit

Interface
REQ-001: Parameter width, default 32, operand width; product width is 2*width.
REQ-002: clk  input  1  rising-edge clock; single clock domain.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: multBegin  input  1  execute-stage request; the held multiply instruction keeps it high while stalled.
REQ-005: isSigned  input  1  1 = two's-complement operands, 0 = unsigned; sampled with multBegin.
REQ-006: multSrc1  input  width  multiplicand, forwarded execute-stage source A.
REQ-007: multSrc2  input  width  multiplier, execute-stage source B after ALU-source select.
REQ-008: multStall  output  1  pipeline stall request; high while a multiply is accepted or in progress.
REQ-009: multOut  output  2*width  registered product {hi, lo}; feeds the hi/lo write path.
REQ-010: multDone  output  1  one-cycle pulse marking the cycle multOut first shows a new product.

Function
REQ-011: FSM states IDLE, BUSY, DONE; encoding free; reset state IDLE.
REQ-012: IDLE with multBegin=1 -> latch operand magnitudes, isSigned and result sign (src1[msb] XOR src2[msb] when signed, else 0); clear the partial product and iteration counter; go to BUSY.
REQ-013: IDLE with multBegin=0 -> stay IDLE, no register change.
REQ-014: BUSY -> one radix-2 shift-add step per cycle; counter increments; after exactly width steps (counter reaches width-1 on the final step) -> DONE.
REQ-015: On the final BUSY step, multOut loads the full 2*width product, two's-complement negated if the latched result sign is 1; multOut changes at no other time except reset.
REQ-016: DONE -> multStall=0, multDone=1 for this cycle only; unconditionally -> IDLE next cycle; multBegin ignored in DONE (same instruction still present, leaving this edge).
REQ-017: multStall = (IDLE AND multBegin) OR BUSY, combinational, so the stall is seen in the request cycle.
REQ-018: Total stall = width+1 cycles (33 at default); product visible on multOut in the DONE cycle and held until the next completion.
REQ-019: Operand and isSigned changes after acceptance have no effect on the running multiply.
REQ-020: Signed mode takes magnitudes by two's-complement negation; the most-negative operand magnitude is 2^(width-1) handled as unsigned, so no overflow error exists.
REQ-021: Back-to-back: a new multBegin in IDLE the cycle after DONE is accepted with no extra bubble.
REQ-022: Zero operands run the full width iterations (fixed latency, no early termination).

Reset
REQ-023: reset=1 at any edge, including mid-BUSY, forces IDLE, multOut=0, multDone=0, counter=0, internal operand/partial registers=0; the in-flight multiply is discarded.
REQ-024: While reset is high multStall=0 regardless of multBegin; the first request after reset deasserts is accepted normally.

Verification
REQ-025: Unsigned 0xFFFFFFFF*0xFFFFFFFF, multBegin held -> multStall high 33 cycles, DONE cycle multOut=0xFFFFFFFE00000001, multDone single pulse.
REQ-026: Signed 0xFFFFFFF9 (-7) * 0x00000003 -> multOut=0xFFFFFFFFFFFFFFEB; signed 0xFFFFFFFF*0xFFFFFFFF -> 0x0000000000000001.
REQ-027: Signed 0x80000000*0x80000000 -> 0x4000000000000000; unsigned same operands -> 0x4000000000000000; signed 0x80000000*0x00000001 -> 0xFFFFFFFF80000000.
REQ-028: Reset asserted at BUSY iteration 10 -> next cycle IDLE, multOut=0, multStall=0; new request 7*6 afterward -> 0x000000000000002A after 33 stall cycles.
REQ-029: Back-to-back: 3*5 then 0x10000*0x10000 (next request in cycle after DONE) -> 0xF then 0x0000000100000000, no idle gap, multBegin held through DONE does not restart.
REQ-030: Operands changed every cycle during BUSY after accepting 12*12 -> multOut=0x90 unaffected; multOut holds 0x90 while idle until next completion.

Source files
------------

// File: rtl/iter_mult_unit.sv
// Iterative radix-2 shift-add multiplier, one partial product per cycle.
// Stalls the pipeline from request through the final step; pulses done once.
module iter_mult_unit #(
  parameter int width = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 multBegin,
  input  logic                 isSigned,
  input  logic [width-1:0]     multSrc1,
  input  logic [width-1:0]     multSrc2,
  output logic                 multStall,
  output logic [2*width-1:0]   multOut,
  output logic                 multDone
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, next_state;

  logic [2*width-1:0] mcand;
  logic [width-1:0]   mplier;
  logic [2*width-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic               a_neg, b_neg;
  logic [width-1:0]   a_mag, b_mag;
  logic [2*width-1:0] step_sum;
  logic [2*width-1:0] prod;

  // Most-negative input negates to itself, read back as an unsigned magnitude.
  assign a_neg    = isSigned & multSrc1[width-1];
  assign b_neg    = isSigned & multSrc2[width-1];
  assign a_mag    = a_neg ? (~multSrc1 + 1'b1) : multSrc1;
  assign b_mag    = b_neg ? (~multSrc2 + 1'b1) : multSrc2;
  assign step_sum = acc + (mplier[0] ? mcand : '0);
  assign prod     = neg ? (~step_sum + 1'b1) : step_sum;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (multBegin) next_state = BUSY;
      BUSY: if (cnt == LAST) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    multStall = 1'b0;
    multDone  = 1'b0;
    if (!reset) begin
      multStall = ((state == IDLE) && multBegin) || (state == BUSY);
    end
    multDone = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      multOut <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (multBegin) begin
            mcand  <= {{width{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
            neg    <= a_neg ^ b_neg;
          end
        end
        BUSY: begin
          acc    <= step_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) multOut <= prod;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mult_unit.sv
// Bench for iter_mult_unit: directed vector table, corner sequences,
// and random operands against an arithmetic reference.
module tb_iter_mult_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        multBegin;
  logic        isSigned;
  logic [31:0] multSrc1;
  logic [31:0] multSrc2;
  logic        multStall;
  logic [63:0] multOut;
  logic        multDone;

  int checks = 0;
  int errors = 0;

  iter_mult_unit #(.width(32)) dut (
    .clk(clk),
    .reset(reset),
    .multBegin(multBegin),
    .isSigned(isSigned),
    .multSrc1(multSrc1),
    .multSrc2(multSrc2),
    .multStall(multStall),
    .multOut(multOut),
    .multDone(multDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  function automatic logic [63:0] ref_mul(
    input logic s, input logic [31:0] a, input logic [31:0] b
  );
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called just after a rising edge with the unit idle.
  task automatic do_mult(
    input logic s, input logic [31:0] a, input logic [31:0] b,
    input bit scramble, output logic [63:0] res,
    output int stalls, output bit got, output bit stall_at_done
  );
    multBegin = 1'b1;
    isSigned  = s;
    multSrc1  = a;
    multSrc2  = b;
    stalls = 0;
    got = 0;
    stall_at_done = 0;
    res = '0;
    for (int c = 0; c < 40; c++) begin
      #3;
      if (multDone) begin
        got = 1;
        res = multOut;
        stall_at_done = multStall;
        break;
      end
      if (multStall) stalls++;
      @(posedge clk);
      #1;
      if (scramble) begin
        multSrc1 = $urandom;
        multSrc2 = $urandom;
        isSigned = $urandom_range(0, 1);
      end
    end
  endtask

  task automatic run_check(input string name, input logic s,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input bit scramble);
    logic [63:0] res;
    int st;
    bit got, sd;
    do_mult(s, a, b, scramble, res, st, got, sd);
    chk({name, "_done"}, 64'(got), 64'd1);
    chk({name, "_prod"}, res, exp);
    chk({name, "_stalls"}, 64'(st), 64'd33);
    chk({name, "_stall_done"}, 64'(sd), 64'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    logic [63:0] r;
    logic [31:0] ra, rb;
    logic rs;
    int st;
    bit got, sd;

    tbl.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001});
    tbl.push_back('{1'b1, 32'hFFFFFFF9, 32'h00000003, 64'hFFFFFFFFFFFFFFEB});
    tbl.push_back('{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001});
    tbl.push_back('{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000});
    tbl.push_back('{1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000});
    tbl.push_back('{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000});
    tbl.push_back('{1'b0, 32'h00000000, 32'h12345678, 64'h0});
    tbl.push_back('{1'b1, 32'h00000000, 32'h00000000, 64'h0});

    reset = 1'b1;
    multBegin = 1'b1;
    isSigned = 1'b0;
    multSrc1 = 32'd3;
    multSrc2 = 32'd4;
    @(posedge clk);
    #1;
    chk("reset_stall", 64'(multStall), 64'd0);
    @(posedge clk);
    #1;
    chk("reset_out", multOut, 64'd0);
    chk("reset_done", 64'(multDone), 64'd0);
    chk("reset_stall2", 64'(multStall), 64'd0);
    reset = 1'b0;
    multBegin = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      run_check($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].b,
                tbl[i].exp, 0);
      multBegin = 1'b0;
    end

    // Back-to-back: second request presented right after DONE.
    do_mult(1'b0, 32'd3, 32'd5, 0, r, st, got, sd);
    chk("b2b_first", r, 64'hF);
    chk("b2b_first_stalls", 64'(st), 64'd33);
    chk("b2b_first_noreq", 64'(sd), 64'd0);
    @(posedge clk);
    #1;
    chk("b2b_pulse_end", 64'(multDone), 64'd0);
    run_check("b2b_second", 1'b0, 32'h10000, 32'h10000,
              64'h0000000100000000, 0);
    multBegin = 1'b0;

    // Operands scrambled during BUSY, then result held while idle.
    run_check("scramble", 1'b0, 32'd12, 32'd12, 64'h90, 1);
    multBegin = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_out", multOut, 64'h90);
    chk("hold_stall", 64'(multStall), 64'd0);

    // Reset at BUSY iteration 10.
    multBegin = 1'b1;
    isSigned = 1'b0;
    multSrc1 = 32'd1000;
    multSrc2 = 32'd1000;
    repeat (11) @(posedge clk);
    #1;
    chk("mid_busy_stall", 64'(multStall), 64'd1);
    reset = 1'b1;
    #2;
    chk("rst_hi_stall", 64'(multStall), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    multBegin = 1'b0;
    #2;
    chk("rst_mid_out", multOut, 64'd0);
    chk("rst_mid_stall", 64'(multStall), 64'd0);
    chk("rst_mid_done", 64'(multDone), 64'd0);
    @(posedge clk);
    #1;
    run_check("after_rst", 1'b0, 32'd7, 32'd6, 64'h2A, 0);
    multBegin = 1'b0;

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = $urandom_range(0, 1);
      if (i % 5 == 1) ra = 32'h80000000;
      run_check($sformatf("rand%0d", i), rs, ra, rb,
                ref_mul(rs, ra, rb), i % 3 == 0);
      multBegin = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
